// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: four-digit, time-multiplexed seven-segment scanner.
// Latches a 16-bit hex value on LD and drives active-low ANODES/CATHODES,
// one digit per DIV_MAX-cycle slot. The first BLANK_CYC cycles of every slot
// are dark to stop ghosting when the anode changes.
// Optional build macro: SSEG_LZ_BLANK_EN enables leading-zero blanking of
// digits 1..3. When it is undefined, all four digits are always shown.
module sseg_scan_driver #(
  parameter int unsigned DIV_MAX   = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic        LD,
  output logic [7:0]  CATHODES,
  output logic [3:0]  ANODES
);

  localparam int unsigned      CNT_W    = $clog2(DIV_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX - 1);

  logic [15:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [1:0]       idx_q,  idx_d;
  logic [3:0]       an_q,   an_d;
  logic [7:0]       cat_q,  cat_d;
  logic             blank;
  logic             dark;

  // Hex digit to active-low segment pattern {dp,g,f,e,d,c,b,a}; dp kept off.
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Select the nibble belonging to digit i (digit 0 is the rightmost).
  function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

  // Next-state for the data latch, slot counter, digit index and the pins.
  always_comb begin
    data_d = LD ? DATA : data_q;

    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

`ifdef SSEG_LZ_BLANK_EN
    // A digit is a leading zero when it and everything to its left is zero;
    // digit 0 always stays visible so a zero value still shows "0".
    case (idx_q)
      2'd1:    blank = (data_q[15:4]  == 12'h000);
      2'd2:    blank = (data_q[15:8]  == 8'h00);
      2'd3:    blank = (data_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif

    dark = (32'(cnt_q) < BLANK_CYC) || blank;

    an_d  = 4'hF;
    cat_d = 8'hFF;
    if (!dark) begin
      an_d  = ~(4'b0001 << idx_q);
      cat_d = hex_seg(nib_sel(data_q, idx_q));
    end
  end

  // State and output registers; reset forces all digits dark immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'hF;
      cat_q  <= 8'hFF;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      cat_q  <= cat_d;
    end
  end

  assign ANODES   = an_q;
  assign CATHODES = cat_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed bench for sseg_scan_driver with DIV_MAX=8,
// BLANK_CYC=2. Edge numbers count rising edges after the last reset release.
module tb_sseg_scan_driver;

  logic        CLK;
  logic        RST;
  logic [15:0] DATA;
  logic        LD;
  logic [7:0]  CATHODES;
  logic [3:0]  ANODES;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

`ifdef SSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  // Hand-written expectations: anode pattern per digit and per-value cathode
  // tables packed as {digit3, digit2, digit1, digit0}.
  localparam logic [15:0] AN_TBL  = {4'h7, 4'hB, 4'hD, 4'hE};
  localparam logic [31:0] CAT1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};
  localparam logic [31:0] CATABCD = {8'h88, 8'h83, 8'hC6, 8'hA1};
  localparam logic [31:0] CAT0000 = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
  localparam logic [31:0] CAT00F0 = {8'hC0, 8'hC0, 8'h8E, 8'hC0};
  localparam logic [31:0] CAT0005 = {8'hC0, 8'hC0, 8'hC0, 8'h92};
  localparam logic [3:0]  LIT_ALL  = 4'b1111;
  localparam logic [3:0]  LIT_0000 = LZ ? 4'b0001 : 4'b1111;
  localparam logic [3:0]  LIT_00F0 = LZ ? 4'b0011 : 4'b1111;
  localparam logic [3:0]  LIT_0005 = LZ ? 4'b0001 : 4'b1111;

  sseg_scan_driver #(
    .DIV_MAX  (8),
    .BLANK_CYC(2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DATA    (DATA),
    .LD      (LD),
    .CATHODES(CATHODES),
    .ANODES  (ANODES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Run edges first..last and check {ANODES,CATHODES} after each.
  task automatic run_edges(input int first, input int last,
                           input logic [31:0] cat, input logic [3:0] lit);
    for (int e = first; e <= last; e++) begin
      int pos;
      int dig;
      logic [11:0] exp;
      step();
      pos = (e - 1) % 8;
      dig = ((e - 1) / 8) % 4;
      if (pos < 2 || !lit[dig]) exp = 12'hFFF;
      else                      exp = {AN_TBL[dig*4 +: 4], cat[dig*8 +: 8]};
      chk($sformatf("edge%0d", e), {ANODES, CATHODES}, exp);
    end
  endtask

  // Continuous pin sanity: at most one anode low, dark pins when no anode,
  // decimal point never lit.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("mon_onehot", {11'b0, (ANODES inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})}, 12'd1);
      chk("mon_dark",   {11'b0, ((ANODES != 4'hF) || (CATHODES == 8'hFF))}, 12'd1);
      chk("mon_dp",     {11'b0, CATHODES[7]}, 12'd1);
    end
  end

  initial begin
    RST  = 1'b1;
    LD   = 1'b0;
    DATA = 16'h0000;
    repeat (3) step();
    chk("reset_state", {ANODES, CATHODES}, 12'hFFF);
    mon_en = 1'b1;

    // Release reset and load 0x1234 on edge 1; one full refresh plus wrap.
    RST  = 1'b0;
    LD   = 1'b1;
    DATA = 16'h1234;
    run_edges(1, 1, CAT1234, LIT_ALL);
    LD = 1'b0;
    run_edges(2, 35, CAT1234, LIT_ALL);

    // Load 0xABCD mid digit 0: old value on the load edge, new one next.
    LD   = 1'b1;
    DATA = 16'hABCD;
    run_edges(36, 36, CAT1234, LIT_ALL);
    LD = 1'b0;
    run_edges(37, 85, CATABCD, LIT_ALL);

    // Pre-edge state is now cnt=5 of digit 2; reset asynchronously.
    #2;
    RST = 1'b1;
    #1;
    chk("async_reset", {ANODES, CATHODES}, 12'hFFF);
    step();
    chk("reset_hold", {ANODES, CATHODES}, 12'hFFF);
    RST = 1'b0;
    run_edges(1, 43, CAT0000, LIT_0000);

    // Digit 1 is lit; load 0x00F0 and see 8E on the following edge.
    LD   = 1'b1;
    DATA = 16'h00F0;
    run_edges(44, 44, CAT0000, LIT_0000);
    LD = 1'b0;
    run_edges(45, 72, CAT00F0, LIT_00F0);

    // Load 0x0005, then 0x0000; blanking depends on the build.
    LD   = 1'b1;
    DATA = 16'h0005;
    run_edges(73, 73, CAT0005, LIT_0005);
    LD = 1'b0;
    run_edges(74, 104, CAT0005, LIT_0005);
    LD   = 1'b1;
    DATA = 16'h0000;
    run_edges(105, 105, CAT0000, LIT_0000);
    LD = 1'b0;
    run_edges(106, 136, CAT0000, LIT_0000);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
